// File: rtl/mip_accumulator.sv
// rtl/mip_accumulator.sv - max-intensity framebuffer accumulator (optional stats via MIP_ACC_STATS_EN)
`timescale 1ns/1ps

module mip_accumulator #(
  parameter int FB_W   = 256,
  parameter int FB_H   = 256,
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_density,
  input  logic [10:0]       in_screenPos_x,
  input  logic [10:0]       in_screenPos_y,
  output logic              out_pipelineStall,
  input  logic              clear_req,
  output logic              clear_done,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [7:0]        fb_rd_data,
  output logic              fb_wr_en,
  output logic [ADDR_W-1:0] fb_wr_addr,
  output logic [7:0]        fb_wr_data
`ifdef MIP_ACC_STATS_EN
  ,
  output logic [31:0]       stat_accepted,
  output logic [31:0]       stat_dropped
`endif
);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN
  } state_t;

  localparam int unsigned NPIX = FB_W * FB_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_wr_en;
  logic [ADDR_W-1:0] clr_addr;

  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [7:0]        a_density;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [7:0]        b_density;
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_addr;
  logic [7:0]        fwd_data;

  logic              accept;
  logic              in_bounds;
  logic [ADDR_W-1:0] pix_addr;
  logic [7:0]        old_val;
  logic [7:0]        new_val;
  logic              clear_entry;

  assign accept    = in_valid & ~out_pipelineStall;
  assign in_bounds = (32'(in_screenPos_x) < 32'(FB_W)) && (32'(in_screenPos_y) < 32'(FB_H));
  assign pix_addr  = ADDR_W'(32'(in_screenPos_y) * 32'(FB_W) + 32'(in_screenPos_x));

  // The RAM is read-first, so a write issued last cycle to the same pixel is
  // not yet visible in fb_rd_data; the forward register covers that gap.
  assign old_val = (fwd_valid && (fwd_addr == b_addr)) ? fwd_data : fb_rd_data;
  assign new_val = (b_density > old_val) ? b_density : old_val;

  // Stage B only ever leaves DRAIN once stage A is empty, so clear writes
  // (which start one cycle after CLEAR is entered) never collide with it.
  assign clear_entry = (state == ST_DRAIN) && !a_valid;

  assign fb_rd_en   = a_valid;
  assign fb_rd_addr = a_addr;
  assign fb_wr_en   = clr_wr_en | b_valid;
  assign fb_wr_addr = b_valid ? b_addr : clr_addr;
  assign fb_wr_data = b_valid ? new_val : 8'd0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= ST_CLEAR;
      clr_cnt           <= '0;
      clr_wr_en         <= 1'b0;
      clr_addr          <= '0;
      out_pipelineStall <= 1'b1;
      clear_done        <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      clr_wr_en  <= 1'b0;
      case (state)
        ST_CLEAR: begin
          out_pipelineStall <= 1'b1;
          clr_wr_en         <= 1'b1;
          clr_addr          <= clr_cnt;
          clr_cnt           <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            state      <= ST_RUN;
            clear_done <= 1'b1;
          end
        end
        ST_RUN: begin
          out_pipelineStall <= clear_req;
          if (clear_req) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          out_pipelineStall <= 1'b1;
          if (clear_entry) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
        default: begin
          state             <= ST_CLEAR;
          clr_cnt           <= '0;
          out_pipelineStall <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_valid   <= 1'b0;
      a_addr    <= '0;
      a_density <= '0;
      b_valid   <= 1'b0;
      b_addr    <= '0;
      b_density <= '0;
      fwd_valid <= 1'b0;
      fwd_addr  <= '0;
      fwd_data  <= '0;
    end else begin
      a_valid <= accept & in_bounds;
      if (accept && in_bounds) begin
        a_addr    <= pix_addr;
        a_density <= in_density;
      end
      b_valid   <= a_valid;
      b_addr    <= a_addr;
      b_density <= a_density;
      fwd_valid <= b_valid;
      if (b_valid) begin
        fwd_addr <= b_addr;
        fwd_data <= new_val;
      end
    end
  end

`ifdef MIP_ACC_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_accepted <= '0;
      stat_dropped  <= '0;
    end else if (clear_entry) begin
      stat_accepted <= '0;
      stat_dropped  <= '0;
    end else begin
      if (b_valid && (stat_accepted != 32'hFFFF_FFFF)) begin
        stat_accepted <= stat_accepted + 32'd1;
      end
      if (accept && !in_bounds && (stat_dropped != 32'hFFFF_FFFF)) begin
        stat_dropped <= stat_dropped + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/mip_accumulator.md
Name: mip_accumulator

Overview:
- Downstream stage of IntensityProjectionCore.
- Consumes its projected samples (screen x/y, density) and performs maximum-intensity accumulation into a screen framebuffer held in an external synchronous single-port-read / single-port-write RAM.
- Read-modify-write is pipelined, with forwarding for back-to-back hits on the same pixel.
- Provides a framebuffer clear sequence and backpressure (stall) to the projection core.

Parameters:
- FB_W, 256, framebuffer width in pixels.
- FB_H, 256, framebuffer height in pixels.
- ADDR_W, 16, framebuffer address width; must satisfy 2^ADDR_W >= FB_W*FB_H.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  sample valid from projection core (its out_valid).
- in_density  input  8  sample density.
- in_screenPos_x  input  11  sample screen x.
- in_screenPos_y  input  11  sample screen y.
- out_pipelineStall  output  1  registered; drives core in_pipelineStall.
- clear_req  input  1  one-cycle pulse requesting framebuffer clear.
- clear_done  output  1  one-cycle pulse when a clear finishes.
- fb_rd_en  output  1  RAM read enable.
- fb_rd_addr  output  ADDR_W  RAM read address.
- fb_rd_data  input  8  RAM read data, valid exactly 1 cycle after fb_rd_en (read-first RAM).
- fb_wr_en  output  1  RAM write enable.
- fb_wr_addr  output  ADDR_W  RAM write address.
- fb_wr_data  output  8  RAM write data.

Behaviour:
- Reset (reset=0, async): state=CLEAR, clear counter=0, out_pipelineStall=1, clear_done=0, fb_rd_en=0, fb_wr_en=0, addresses/data=0, all pipeline valids=0, forward register invalid.
- FSM states: CLEAR, RUN, DRAIN.
  - CLEAR: each cycle fb_wr_en=1, fb_wr_addr=counter, fb_wr_data=0, counter++. After address FB_W*FB_H-1 is written: go to RUN, pulse clear_done for 1 cycle, deassert stall on the next cycle.
  - RUN: samples accepted. clear_req=1 -> DRAIN, stall=1 from the next cycle.
  - DRAIN: wait until stage A, stage B and the final write are empty (at most 2 cycles) -> CLEAR with counter=0.
- Acceptance: sample accepted iff in_valid=1 and out_pipelineStall=0 in the same cycle. Samples with stall=1 are ignored (upstream holds them).
- Stage A (1 cycle after acceptance): bounds check x<FB_W and y<FB_H.
  - Out-of-bounds: dropped, no RAM access.
  - Otherwise addr = y*FB_W + x (truncated to ADDR_W), fb_rd_en=1, fb_rd_addr=addr.
- Stage B (next cycle): old = fb_rd_data, unless forward register valid with matching addr, in which case old = forward data. new = max(old, density), unsigned 8-bit. fb_wr_en=1, fb_wr_addr=addr, fb_wr_data=new. Forward register <= {addr,new,valid}; invalidated when stage B is empty.
- Latency: acceptance -> write issued = 2 cycles. Throughput 1 sample/cycle, no bubbles, including consecutive identical pixels.
- Equal densities: write still issued (value unchanged).
- clear_req during CLEAR or DRAIN: ignored.
- clear_req in the same cycle as an accepted sample: sample is processed (drained) before the clear.
- Reset mid-clear or mid-pipeline: in-flight work discarded, clear restarts from address 0.

Optional Feature:
- Macro MIP_ACC_STATS_EN.
- Defined: adds outputs stat_accepted[31:0] and stat_dropped[31:0].
  - stat_accepted counts in-bounds samples written.
  - stat_dropped counts out-of-bounds samples.
  - Both zeroed by reset and on entry to CLEAR; saturate at 0xFFFFFFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset release with FB_W=4, FB_H=4: 16 consecutive zero writes to addr 0..15, clear_done pulses once, stall falls the cycle after; first sample accepted only then.
- Single sample x=2,y=1,density=0x40 on a cleared FB: read addr 6 at +1, write addr 6 data 0x40 at +2.
- Back-to-back same pixel x=1,y=1, densities 0x10,0x80,0x20 on consecutive cycles: writes to addr 5 of 0x10, 0x80, 0x80 (forwarding exercised); final RAM[5]=0x80.
- Out-of-bounds x=4,y=0 and x=0,y=7 (FB 4x4): no fb_rd_en/fb_wr_en; with MIP_ACC_STATS_EN, stat_dropped=2 and stat_accepted unchanged.
- clear_req while 2 samples are in flight: both writes complete, then 16 zero writes, clear_done pulse; samples presented during stall produce no RAM access.
- Reset asserted midway through clear (counter=7): outputs return to reset values immediately; after release, clear restarts at addr 0.
